// File: rtl/banner_scroll_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : banner_scroll_ctrl                                            |
// | Purpose  : Slides an 8-digit circular window across a loadable message   |
// |            and drives the 32-bit seven-segment digit bus.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module banner_scroll_ctrl #(
    parameter int MAX_LEN     = 32,
    parameter int STEP_DIV    = 25_000_000,
    parameter int PAUSE_STEPS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [3:0]  wr_data,
    input  logic [5:0]  msg_len,
    input  logic        start,
    input  logic        stop,
    input  logic        dir,
    output logic        busy,
    output logic        wrap_pulse,
    output logic [31:0] current_disp
);

    localparam int              c_PW       = $clog2(STEP_DIV);
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(STEP_DIV - 1);
    localparam logic [c_PW-1:0] c_PRE_ONE  = c_PW'(1);
    localparam logic [5:0]      c_MAX_LEN  = 6'(MAX_LEN);
    localparam logic [4:0]      c_PAUSE    = 5'(PAUSE_STEPS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]      r_state;
    logic [3:0]      r_msg [MAX_LEN];
    logic [4:0]      r_offset;
    logic [4:0]      r_pause;
    logic [5:0]      r_len;
    logic [c_PW-1:0] r_pre;
    logic            r_wrap;
    logic [31:0]     r_disp;

    logic            w_step;
    logic            w_addr_ok;
    logic [4:0]      w_last;
    logic [4:0]      w_off_next;
    logic [5:0]      w_len_in;
    logic [31:0]     w_window;

    assign w_step   = (r_pre == c_PRE_LAST);
    assign w_last   = 5'(r_len - 6'd1);
    assign w_len_in = (msg_len > c_MAX_LEN) ? c_MAX_LEN : msg_len;

    generate
        if (MAX_LEN >= 32) begin : g_full_addr
            assign w_addr_ok = 1'b1;
        end else begin : g_part_addr
            assign w_addr_ok = (wr_addr < 5'(MAX_LEN));
        end
    endgenerate

    // Walk the index forward one digit at a time, wrapping at len-1, so no divider is needed.
    always_comb begin
        logic [4:0] v_idx;
        v_idx    = r_offset;
        w_window = '0;
        for (int k = 0; k < 8; k++) begin
            w_window[(7-k)*4 +: 4] = r_msg[v_idx];
            v_idx = (v_idx == w_last) ? 5'd0 : v_idx + 5'd1;
        end
    end

    always_comb begin
        if (dir) w_off_next = (r_offset == 5'd0)   ? w_last : r_offset - 5'd1;
        else     w_off_next = (r_offset == w_last) ? 5'd0   : r_offset + 5'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_offset <= 5'd0;
            r_pause  <= 5'd0;
            r_len    <= 6'd8;
            r_pre    <= '0;
            r_wrap   <= 1'b0;
            r_disp   <= 32'h0;
            for (int i = 0; i < MAX_LEN; i++) r_msg[i] <= 4'd0;
        end else begin
            r_wrap <= 1'b0;
            r_disp <= w_window;
            if (stop) begin
                r_state  <= S_IDLE;
                r_offset <= 5'd0;
                r_pause  <= 5'd0;
                r_pre    <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (wr_en && w_addr_ok) r_msg[wr_addr] <= wr_data;
                        if (start && (msg_len != 6'd0)) begin
                            r_state <= S_RUN;
                            r_len   <= w_len_in;
                            r_pre   <= '0;
                        end
                    end
                    S_RUN: begin
                        r_pre <= w_step ? '0 : r_pre + c_PRE_ONE;
                        if (w_step) begin
                            r_offset <= w_off_next;
                            if (w_off_next == 5'd0) begin
                                r_wrap <= 1'b1;
                                if (PAUSE_STEPS > 0) begin
                                    r_state <= S_HOLD;
                                    r_pause <= 5'd0;
                                end
                            end
                        end
                    end
                    S_HOLD: begin
                        r_pre <= w_step ? '0 : r_pre + c_PRE_ONE;
                        if (w_step) begin
                            r_pause <= r_pause + 5'd1;
                            if (r_pause + 5'd1 == c_PAUSE) r_state <= S_RUN;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign wrap_pulse   = r_wrap;
    assign current_disp = r_disp;

endmodule
`default_nettype wire
